cht_shift_bank: RTL and testbench
=================================

# cht_shift_bank

Parametrised bank of CHANNELS independent WIDTH-bit registered shift chains with a synchronous clear, two-source parallel load, bidirectional single-step shift, optional cascade of all chains into one long chain, and a counted burst-shift engine with busy/done handshake. It is the clocked successor to the fixed-width combinational shift/load next-state logic in the mcnc91 set, for use wherever a design needs the held state rather than only the next-state function.

## Interface
- WIDTH, 14: bits per chain (≥2)
- CHANNELS, 2: number of chains (≥1)
- CNT_W, $clog2(WIDTH*CHANNELS+1): burst length width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear, highest priority
- load_en  in  1  parallel load all chains
- load_sel  in  1  0 = load_a, 1 = load_b
- load_a  in  CHANNELS*WIDTH  source A, chain k at [k*WIDTH +: WIDTH]
- load_b  in  CHANNELS*WIDTH  source B, same packing
- shift_en  in  1  single-step shift this cycle
- dir  in  1  0 = toward MSB (serial in at bit 0), 1 = toward LSB (serial in at bit WIDTH-1)
- ser_in  in  CHANNELS  per-chain serial input
- cascade  in  1  link chains into one CHANNELS*WIDTH chain
- burst_start  in  1  request burst of burst_len shifts
- burst_len  in  CNT_W  shift count, sampled on accepted burst_start
- burst_busy  out  1  burst in progress
- burst_done  out  1  one-cycle pulse at burst completion
- q  out  CHANNELS*WIDTH  chain contents (registered)
- ser_out  out  CHANNELS  dir=0: q_k[WIDTH-1]; dir=1: q_k[0] (combinational from q and dir)

## Operation
- Reset (rst_n=0, async): q=0, FSM=IDLE, counter=0, burst_busy=0, burst_done=0.
- Per-cycle action priority: clr > load_en > burst shift (BURST state) > shift_en > hold.
- clr: q←0; FSM→IDLE; counter←0; no burst_done pulse (abort).
- load_en: q←load_sel ? load_b : load_a. In BURST, the shift is stalled that cycle (counter not decremented).
- Shift, dir=0: q_k←{q_k[WIDTH-2:0], sin_k}. dir=1: q_k←{sin_k, q_k[WIDTH-1:1]}. All chains shift together.
- sin_k, cascade=0: ser_in[k].
- sin_k, cascade=1, dir=0: k=0 → ser_in[0]; k>0 → ser_out[k-1].
- sin_k, cascade=1, dir=1: k=CHANNELS-1 → ser_in[CHANNELS-1]; otherwise ser_out[k+1].
- dir and cascade are sampled each shift cycle; changing them mid-burst takes effect on the next shift.
- FSM states: IDLE, BURST.
  - IDLE: burst_start and not clr → counter←burst_len; enter BURST when burst_len≠0. burst_len=0 → stay IDLE and pulse burst_done next cycle, no shift.
  - BURST: each non-stalled cycle shifts once and decrements the counter. The shift that brings the counter 1→0 returns to IDLE and asserts burst_done in the following cycle.
- burst_start while busy: ignored. shift_en while busy: ignored (the burst performs the shift).
- burst_busy = (FSM==BURST), registered.

## Timing
- All q updates take effect at the rising edge after the controlling inputs are sampled. The load-to-q latency is one cycle.
- A burst of length N accepted at edge 0:
  - burst_busy is high after edges 0..N-1.
  - Shifts occur at edges 1..N, plus one extra cycle per stall.
  - burst_done is high for exactly one cycle, after edge N.
  - burst_busy is low in the same cycle that burst_done is high.
- burst_start is accepted in the burst_done cycle (IDLE). Back-to-back bursts have zero gap.
- ser_out follows q and dir with no register delay.
- rst_n assertion mid-burst clears immediately with no done pulse. Deassertion is synchronised externally.

## Test plan
- Reset/clear: WIDTH=8, CHANNELS=2; load_a=16'hA55A, load_en=1, then clr=1 together with load_en=1 → q=16'h0000, busy=0.
- Load select: load_b=16'h1234, load_sel=1, load_en=1 → q=16'h1234 after one cycle. Next cycle load_sel=0 with load_a=16'hBEEF → q=16'hBEEF.
- Independent shift: q=16'h0180, cascade=0, dir=0, ser_in=2'b00, shift_en=1 for 1 cycle → q=16'h0200 (chain0 MSB lost, not passed to chain1). With cascade=1 the same start gives q=16'h0300.
- Right shift cascade: q=16'h0100, cascade=1, dir=1, ser_in=2'b10, one shift → q=16'h8080.
- Burst: q=16'h0001, cascade=1, dir=0, ser_in=0, burst_len=9, burst_start=1 → busy for 9 cycles, done pulse in cycle 10, q=16'h0200. burst_len=0 → done next cycle, q unchanged, busy never high.
- Burst interactions:
  - load_en in burst cycle 3 → loaded value, burst completes one cycle late.
  - clr in cycle 5 → q=0, busy=0, no done pulse.
  - burst_start during busy → ignored.

Source files
------------

// File: rtl/cht_shift_bank_if.sv
// Control/data bundle for cht_shift_bank: load, shift and burst requests in; chain state out.
// The master modport is the driving side, and the slave modport is the shift bank.
interface cht_shift_bank_if #(
  parameter int unsigned WIDTH    = 14,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = $clog2(WIDTH * CHANNELS + 1)
);
  logic                        clr;
  logic                        load_en;
  logic                        load_sel;
  logic [CHANNELS*WIDTH-1:0]   load_a;
  logic [CHANNELS*WIDTH-1:0]   load_b;
  logic                        shift_en;
  logic                        dir;
  logic [CHANNELS-1:0]         ser_in;
  logic                        cascade;
  logic                        burst_start;
  logic [CNT_W-1:0]            burst_len;
  logic                        burst_busy;
  logic                        burst_done;
  logic [CHANNELS*WIDTH-1:0]   q;
  logic [CHANNELS-1:0]         ser_out;

  modport master (
    output clr, load_en, load_sel, load_a, load_b, shift_en, dir, ser_in, cascade,
           burst_start, burst_len,
    input  burst_busy, burst_done, q, ser_out
  );

  modport slave (
    input  clr, load_en, load_sel, load_a, load_b, shift_en, dir, ser_in, cascade,
           burst_start, burst_len,
    output burst_busy, burst_done, q, ser_out
  );
endinterface

// File: rtl/cht_shift_bank.sv
// Bank of CHANNELS registered WIDTH-bit shift chains with clear, load, optional cascading
// and a counted burst-shift engine that reports busy/done.
module cht_shift_bank #(
  parameter int unsigned WIDTH    = 14,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = $clog2(WIDTH * CHANNELS + 1)
) (
  input logic              clk,
  input logic              rst_n,
  cht_shift_bank_if.slave  bus
);
  localparam int unsigned N = WIDTH * CHANNELS;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     shifted;
  logic             do_shift;

  // In cascade mode the chain boundaries vanish: one flat shift of the whole vector.
  always_comb begin
    shifted = q_q;
    if (bus.cascade) begin
      if (bus.dir) shifted = {bus.ser_in[CHANNELS-1], q_q[N-1:1]};
      else         shifted = {q_q[N-2:0], bus.ser_in[0]};
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (bus.dir) begin
          shifted[k*WIDTH +: WIDTH] = {bus.ser_in[k], q_q[k*WIDTH+1 +: WIDTH-1]};
        end else begin
          shifted[k*WIDTH +: WIDTH] = {q_q[k*WIDTH +: WIDTH-1], bus.ser_in[k]};
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      bus.ser_out[k] = bus.dir ? q_q[k*WIDTH] : q_q[k*WIDTH+WIDTH-1];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    q_d      = q_q;
    do_shift = 1'b0;

    if (bus.clr) begin
      state_d = StIdle;
      cnt_d   = '0;
      q_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          do_shift = bus.shift_en;
          if (bus.burst_start) begin
            cnt_d = bus.burst_len;
            if (bus.burst_len != '0) state_d = StBurst;
            else                     done_d  = 1'b1;
          end
        end
        StBurst: begin
          // A load stalls the burst: no shift and no count this cycle.
          if (!bus.load_en) begin
            do_shift = 1'b1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (bus.load_en)   q_d = bus.load_sel ? bus.load_b : bus.load_a;
      else if (do_shift) q_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      q_q     <= q_d;
    end
  end

  assign bus.q          = q_q;
  assign bus.burst_busy = (state_q == StBurst);
  assign bus.burst_done = done_q;
endmodule

// File: tb/tb_cht_shift_bank.sv
// Directed bench for cht_shift_bank (WIDTH=8, CHANNELS=2) with an expected-state scoreboard
// popped one entry per clock edge.
module tb_cht_shift_bank;
  localparam int unsigned W  = 8;
  localparam int unsigned C  = 2;
  localparam int unsigned CW = $clog2(W * C + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cht_shift_bank_if #(.WIDTH(W), .CHANNELS(C), .CNT_W(CW)) bus ();

  cht_shift_bank #(.WIDTH(W), .CHANNELS(C), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] q;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] mq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [15:0] q, input logic busy,
                              input logic done);
    exp_t e;
    e.tag  = tag;
    e.q    = q;
    e.busy = busy;
    e.done = done;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_q"},    32'(bus.q),          32'(e.q));
      chk({e.tag, "_busy"}, 32'(bus.burst_busy), 32'(e.busy));
      chk({e.tag, "_done"}, 32'(bus.burst_done), 32'(e.done));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_front();
  endtask

  // Reference shift for the 2x8 configuration, written chain by chain.
  function automatic logic [15:0] shift_model(input logic [15:0] v, input logic dir,
                                              input logic casc, input logic [1:0] si);
    logic [7:0] c0, c1, n0, n1;
    logic       sin0, sin1;
    c0 = v[7:0];
    c1 = v[15:8];
    if (!casc) begin
      sin0 = si[0];
      sin1 = si[1];
    end else if (!dir) begin
      sin0 = si[0];
      sin1 = c0[7];
    end else begin
      sin0 = c1[0];
      sin1 = si[1];
    end
    if (!dir) begin
      n0 = {c0[6:0], sin0};
      n1 = {c1[6:0], sin1};
    end else begin
      n0 = {sin0, c0[7:1]};
      n1 = {sin1, c1[7:1]};
    end
    return {n1, n0};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.clr = 0; bus.load_en = 0; bus.load_sel = 0; bus.load_a = '0; bus.load_b = '0;
    bus.shift_en = 0; bus.dir = 0; bus.ser_in = '0; bus.cascade = 0;
    bus.burst_start = 0; bus.burst_len = '0;

    #2;
    expect_state("reset", 16'h0000, 0, 0);
    compare_front();
    #1 rst_n = 1'b1;

    // Load, then clear beats a simultaneous load.
    bus.load_a = 16'hA55A; bus.load_en = 1;
    expect_state("load_a", 16'hA55A, 0, 0); tick();
    bus.clr = 1;
    expect_state("clr_over_load", 16'h0000, 0, 0); tick();
    bus.clr = 0;

    bus.load_b = 16'h1234; bus.load_sel = 1;
    expect_state("load_b", 16'h1234, 0, 0); tick();
    bus.load_sel = 0; bus.load_a = 16'hBEEF;
    expect_state("load_sel0", 16'hBEEF, 0, 0); tick();

    // Independent versus cascaded left shift.
    bus.load_a = 16'h0180;
    expect_state("load_0180", 16'h0180, 0, 0); tick();
    chk("ser_out_dir0", 32'(bus.ser_out), 32'(2'b01));
    bus.load_en = 0; bus.shift_en = 1; bus.cascade = 0; bus.dir = 0; bus.ser_in = 2'b00;
    expect_state("shl_indep", 16'h0200, 0, 0); tick();
    bus.shift_en = 0; bus.load_en = 1;
    expect_state("reload_0180", 16'h0180, 0, 0); tick();
    bus.load_en = 0; bus.shift_en = 1; bus.cascade = 1;
    expect_state("shl_casc", 16'h0300, 0, 0); tick();

    // Cascaded right shift.
    bus.shift_en = 0; bus.load_en = 1; bus.load_a = 16'h0100;
    expect_state("load_0100", 16'h0100, 0, 0); tick();
    bus.dir = 1;
    #1 chk("ser_out_dir1", 32'(bus.ser_out), 32'(2'b10));
    bus.load_en = 0; bus.shift_en = 1; bus.ser_in = 2'b10;
    expect_state("shr_casc", 16'h8080, 0, 0); tick();
    bus.shift_en = 0;

    // Burst of 9, cascaded left; a second burst_start while busy is ignored.
    bus.load_en = 1; bus.load_a = 16'h0001; bus.dir = 0; bus.ser_in = 2'b00;
    expect_state("load_0001", 16'h0001, 0, 0); tick();
    bus.load_en = 0; bus.burst_len = CW'(9); bus.burst_start = 1;
    mq = 16'h0001;
    expect_state("b9_accept", mq, 1, 0); tick();
    for (int i = 1; i <= 9; i++) begin
      if (i == 4) begin
        bus.burst_start = 1; bus.burst_len = CW'(2);
      end else begin
        bus.burst_start = 0;
      end
      mq = shift_model(mq, bus.dir, bus.cascade, bus.ser_in);
      if (i == 9) expect_state("b9_last", mq, 0, 1);
      else        expect_state("b9_run", mq, 1, 0);
      tick();
    end
    chk("b9_final_q", 32'(bus.q), 32'(16'h0200));
    expect_state("b9_done_drop", mq, 0, 0); tick();

    // Zero-length burst: done next cycle, no shift, never busy.
    bus.burst_len = '0; bus.burst_start = 1;
    expect_state("b0_done", mq, 0, 1); tick();
    bus.burst_start = 0;
    expect_state("b0_after", mq, 0, 0); tick();

    // Burst of 4 with a load stall in cycle 3, then a back-to-back burst of 1.
    bus.load_en = 1; bus.load_a = 16'h0001; bus.cascade = 0;
    expect_state("load_b4", 16'h0001, 0, 0); tick();
    bus.load_en = 0; bus.burst_len = CW'(4); bus.burst_start = 1;
    mq = 16'h0001;
    expect_state("b4_accept", mq, 1, 0); tick();
    bus.burst_start = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) begin
        bus.load_en = 1; bus.load_a = 16'h0F0F; mq = 16'h0F0F;
      end else begin
        bus.load_en = 0;
        mq = shift_model(mq, bus.dir, bus.cascade, bus.ser_in);
      end
      if (i == 5) expect_state("b4_last", mq, 0, 1);
      else        expect_state("b4_run", mq, 1, 0);
      tick();
    end
    chk("b4_final_q", 32'(bus.q), 32'(16'h3C3C));
    bus.burst_len = CW'(1); bus.burst_start = 1; bus.dir = 1; bus.ser_in = 2'b01;
    expect_state("b2b_accept", mq, 1, 0); tick();
    bus.burst_start = 0;
    mq = shift_model(mq, bus.dir, bus.cascade, bus.ser_in);
    expect_state("b2b_done", mq, 0, 1); tick();
    chk("b2b_final_q", 32'(bus.q), 32'(16'h1E9E));

    // Clear in cycle 5 of a burst aborts it without a done pulse.
    bus.cascade = 1; bus.dir = 0; bus.burst_len = CW'(8); bus.burst_start = 1;
    expect_state("b8_accept", mq, 1, 0); tick();
    bus.burst_start = 0;
    for (int i = 1; i <= 4; i++) begin
      mq = shift_model(mq, bus.dir, bus.cascade, bus.ser_in);
      expect_state("b8_run", mq, 1, 0); tick();
    end
    bus.clr = 1;
    expect_state("b8_clr", 16'h0000, 0, 0); tick();
    bus.clr = 0;
    expect_state("b8_post1", 16'h0000, 0, 0); tick();
    expect_state("b8_post2", 16'h0000, 0, 0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
